// File: rtl/led_fade_pwm.sv
// PWM LED driver that ramps each channel's brightness linearly between off and full on.
// Define LED_FADE_GAMMA_EN to map duty through a square-law perceptual curve.
module led_fade_pwm #(
  parameter int NLED     = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NLED-1:0] led_in,
  output logic [NLED-1:0] pwm_out,
  output logic            busy
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] DMAX    = '1;
  localparam logic [PWM_BITS-1:0] DMAX_M1 = DMAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DONE    = PWM_BITS'(1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t              state_q [NLED];
  state_t              state_d [NLED];
  logic [PWM_BITS-1:0] duty_q  [NLED];
  logic [PWM_BITS-1:0] duty_d  [NLED];
  logic [PWM_BITS-1:0] level   [NLED];

  logic [NLED-1:0]     led_q;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic                step_tick;
  logic [NLED-1:0]     pwm_out_q, pwm_out_d;
  logic                busy_q, busy_d;

  assign step_tick  = (step_cnt_q == STEP_LAST);
  assign step_cnt_d = step_tick ? '0 : step_cnt_q + SW'(1);
  assign pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);

  // A direction reversal takes priority over a step landing in the same cycle.
  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      case (state_q[i])
        OFF: begin
          duty_d[i] = '0;
          if (led_q[i]) state_d[i] = RISE;
        end
        RISE: begin
          if (!led_q[i]) begin
            state_d[i] = FALL;
          end else if (duty_q[i] == DMAX) begin
            state_d[i] = ON;
          end else if (step_tick) begin
            duty_d[i] = duty_q[i] + PWM_BITS'(1);
            if (duty_q[i] == DMAX_M1) state_d[i] = ON;
          end
        end
        ON: begin
          duty_d[i] = DMAX;
          if (!led_q[i]) state_d[i] = FALL;
        end
        FALL: begin
          if (led_q[i]) begin
            state_d[i] = RISE;
          end else if (duty_q[i] == '0) begin
            state_d[i] = OFF;
          end else if (step_tick) begin
            duty_d[i] = duty_q[i] - PWM_BITS'(1);
            if (duty_q[i] == DONE) state_d[i] = OFF;
          end
        end
        default: begin
          state_d[i] = OFF;
          duty_d[i]  = '0;
        end
      endcase
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_wide [NLED];
  logic [2*PWM_BITS-1:0] duty_sq   [NLED];

  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      duty_wide[i] = (2*PWM_BITS)'(duty_d[i]);
      duty_sq[i]   = duty_wide[i] * duty_wide[i];
      level[i]     = PWM_BITS'(duty_sq[i] >> PWM_BITS);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      level[i] = duty_d[i];
    end
  end
`endif

  // Outputs are computed from next-state values so they line up with the registered state.
  always_comb begin
    busy_d    = 1'b0;
    pwm_out_d = '0;
    for (int i = 0; i < NLED; i++) begin
      case (state_d[i])
        ON:      pwm_out_d[i] = 1'b1;
        OFF:     pwm_out_d[i] = 1'b0;
        default: pwm_out_d[i] = (pwm_cnt_d < level[i]);
      endcase
      if (state_d[i] == RISE || state_d[i] == FALL) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      pwm_out_q  <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NLED; i++) begin
        state_q[i] <= OFF;
        duty_q[i]  <= '0;
      end
    end else begin
      led_q      <= led_in;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      pwm_out_q  <= pwm_out_d;
      busy_q     <= busy_d;
      for (int i = 0; i < NLED; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  assign pwm_out = pwm_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: vector table, corner-case sequences and
// random stimulus, all compared against a behavioural brightness model.
module tb_led_fade_pwm;

  localparam int NLED = 4;
  localparam int PB   = 4;
  localparam int SD   = 2;
  localparam int DMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [NLED-1:0] led_in;
  logic [NLED-1:0] pwm_out;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: brightness, whether it is moving, and which way.
  int              mDuty   [NLED];
  bit              mMoving [NLED];
  bit              mUp     [NLED];
  logic [NLED-1:0] mLedQ;
  int              mStep;
  int              mPwm;

  typedef struct {
    logic [NLED-1:0] led;
    int              hold;
    logic [NLED-1:0] expPwm;
    logic            expBusy;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  led_fade_pwm #(
    .NLED    (NLED),
    .PWM_BITS(PB),
    .STEP_DIV(SD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .led_in (led_in),
    .pwm_out(pwm_out),
    .busy   (busy)
  );

  function automatic int levelOf(input int d);
`ifdef LED_FADE_GAMMA_EN
    return (d * d) / (1 << PB);
`else
    return d;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NLED; i++) begin
      mDuty[i]   = 0;
      mMoving[i] = 0;
      mUp[i]     = 0;
    end
    mLedQ = '0;
    mStep = 0;
    mPwm  = 0;
  endtask

  task automatic modelStep(input logic [NLED-1:0] v);
    bit tick;
    int target;
    tick = (mStep == SD - 1);
    for (int i = 0; i < NLED; i++) begin
      if (!mMoving[i]) begin
        if (mLedQ[i] != (mDuty[i] == DMAX)) begin
          mMoving[i] = 1;
          mUp[i]     = mLedQ[i];
        end
      end else if (mLedQ[i] != mUp[i]) begin
        mUp[i] = mLedQ[i];
      end else begin
        target = mUp[i] ? DMAX : 0;
        if (mDuty[i] == target) begin
          mMoving[i] = 0;
        end else if (tick) begin
          mDuty[i] = mDuty[i] + (mUp[i] ? 1 : -1);
          if (mDuty[i] == target) mMoving[i] = 0;
        end
      end
    end
    mLedQ = v;
    mStep = (mStep + 1) % SD;
    mPwm  = (mPwm + 1) % (DMAX + 1);
  endtask

  function automatic logic [NLED-1:0] modelPwm();
    logic [NLED-1:0] p;
    for (int i = 0; i < NLED; i++) begin
      if (!mMoving[i]) p[i] = (mDuty[i] == DMAX);
      else             p[i] = (mPwm < levelOf(mDuty[i]));
    end
    return p;
  endfunction

  function automatic logic modelBusy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NLED; i++) b = b | mMoving[i];
    return b;
  endfunction

  task automatic checkEq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle and checks against the model.
  task automatic applyStimulus(input logic [NLED-1:0] v);
    led_in = v;
    @(posedge clk);
    modelStep(v);
    @(negedge clk);
    checkEq("pwm_out", pwm_out, modelPwm());
    checkEq("busy", busy, modelBusy());
  endtask

  task automatic checkOutput(input string name, input logic [NLED-1:0] expPwm, input logic expBusy);
    checkEq({name, "_pwm"}, pwm_out, expPwm);
    checkEq({name, "_busy"}, busy, expBusy);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit found;

    vecs[0] = '{led: 4'b0000, hold: 100, expPwm: 4'b0000, expBusy: 1'b0};
    vecs[1] = '{led: 4'b0001, hold: 40,  expPwm: 4'b0001, expBusy: 1'b0};
    vecs[2] = '{led: 4'b0000, hold: 40,  expPwm: 4'b0000, expBusy: 1'b0};
    vecs[3] = '{led: 4'b1111, hold: 40,  expPwm: 4'b1111, expBusy: 1'b0};
    vecs[4] = '{led: 4'b0101, hold: 40,  expPwm: 4'b0101, expBusy: 1'b0};
    vecs[5] = '{led: 4'b0000, hold: 40,  expPwm: 4'b0000, expBusy: 1'b0};

    rst    = 1'b1;
    led_in = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset", 4'b0000, 1'b0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < vecs[v].hold; c++) applyStimulus(vecs[v].led);
      checkOutput($sformatf("vec%0d", v), vecs[v].expPwm, vecs[v].expBusy);
    end

    // Ramp start latency: input register plus one cycle to enter RISE.
    applyStimulus(4'b0001);
    checkEq("riseEdge1_busy", busy, 0);
    applyStimulus(4'b0001);
    checkEq("riseEdge2_busy", busy, 1);
    for (int c = 0; c < 40; c++) applyStimulus(4'b0000);

    // Reverse right after the step to duty 5; the reversal coincides with the next tick.
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      applyStimulus(4'b0001);
      if (mMoving[0] && mUp[0] && mDuty[0] == 5) found = 1;
    end
    checkEq("reachDuty5", found, 1);
    n = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      applyStimulus(4'b0000);
      n++;
      if (busy == 1'b0) found = 1;
    end
    checkEq("reverseToOff_edges", n, 12);
    checkOutput("reverseDone", 4'b0000, 1'b0);

    // Asynchronous reset in the middle of two ramps.
    for (int c = 0; c < 12; c++) applyStimulus(4'b0101);
    checkEq("midRamp_busy", busy, 1);
    #2 rst = 1'b1;
    #1 checkOutput("asyncReset", 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b0101);
    checkEq("restart_busy", busy, 0);
    for (int c = 0; c < 40; c++) applyStimulus(4'b0101);
    checkOutput("restartOn", 4'b0101, 1'b0);

    // Random pattern changes, including mid-ramp reversals.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) applyStimulus(4'($urandom));
      else                           applyStimulus(led_in);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
